// File: rtl/fpu_pkg.sv
// Shared types, command encodings and width helpers for the fpu and its arbiter.
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } arb_state_t;

   localparam logic [1:0] CMD_ADD = 2'd0;
   localparam logic [1:0] CMD_SUB = 2'd1;
   localparam logic [1:0] CMD_MUL = 2'd2;
   localparam logic [1:0] CMD_DIV = 2'd3;

   // IEEE-754 field widths for the supported operand sizes
   function automatic int exp_width(input int bitness);
      case (bitness)
         16:      return 5;
         64:      return 11;
         default: return 8;
      endcase
   endfunction

   function automatic int mant_width(input int bitness);
      return bitness - exp_width(bitness) - 1;
   endfunction

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after last_grant, wrapping around.
module rr_pick
   import fpu_pkg::*;
#(
   parameter int REQUESTERS = 4,
   parameter int INDEX_W    = index_width(REQUESTERS)
) (
   input  logic [REQUESTERS-1:0] req,
   input  logic [INDEX_W-1:0]    last_grant,
   output logic [REQUESTERS-1:0] onehot,
   output logic [INDEX_W-1:0]    index
);

   logic [31:0]        cand;
   logic [INDEX_W-1:0] ci;
   logic               found;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      cand   = '0;
      ci     = '0;
      for (int unsigned k = 1; k <= 32'(REQUESTERS); k++) begin
         cand = (32'(last_grant) + k) % 32'(REQUESTERS);
         ci   = INDEX_W'(cand);
         if (!found && req[ci]) begin
            found      = 1'b1;
            onehot[ci] = 1'b1;
            index      = ci;
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares a single fpu among REQUESTERS clients: round-robin accept, operand
// capture, restart pulse, bounded completion wait and result return.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int bitness      = 32,
   parameter int command_size = 2,
   parameter int REQUESTERS   = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [REQUESTERS-1:0]            req_valid,
   output logic [REQUESTERS-1:0]            req_ready,
   input  logic [REQUESTERS*bitness-1:0]    req_first,
   input  logic [REQUESTERS*bitness-1:0]    req_second,
   input  logic [REQUESTERS*bitness-1:0]    req_z,
   input  logic [REQUESTERS*command_size-1:0] req_command,
   output logic [REQUESTERS-1:0]            resp_valid,
   input  logic [REQUESTERS-1:0]            resp_ready,
   output logic [bitness-1:0]               resp_result,
   output logic                             resp_timeout,
   output logic                             fpu_start,
   output logic [bitness-1:0]               fpu_first,
   output logic [bitness-1:0]               fpu_second,
   output logic [bitness-1:0]               fpu_z,
   output logic [command_size-1:0]          fpu_command,
   input  logic [bitness-1:0]               fpu_result,
   input  logic                             fpu_done
);

   localparam int IW = index_width(REQUESTERS);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t            state, next_state;
   logic [IW-1:0]         last_grant, grant, pick_index;
   logic [REQUESTERS-1:0] pick_onehot;
   logic [CW-1:0]         counter;
   logic [31:0]           op_base, cmd_base;
   logic                  accept, done_ok, timed_out, resp_hs;

   rr_pick #(
      .REQUESTERS(REQUESTERS),
      .INDEX_W   (IW)
   ) u_rr_pick (
      .req       (req_valid),
      .last_grant(last_grant),
      .onehot    (pick_onehot),
      .index     (pick_index)
   );

   // done is stale in the first WAIT cycle (counter still 0), so it only counts afterwards
   always_comb begin
      accept    = (state == IDLE) && (|req_valid);
      done_ok   = (state == WAIT) && (counter != '0) && fpu_done;
      timed_out = (state == WAIT) && (counter == CW'(TIMEOUT - 1));
      resp_hs   = (state == RESPOND) && resp_ready[grant];
      op_base   = 32'(pick_index) * 32'(bitness);
      cmd_base  = 32'(pick_index) * 32'(command_size);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (done_ok || timed_out) next_state = RESPOND;
         RESPOND: if (resp_hs) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // req_ready is gated by reset so nothing is offered while reset is held
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      fpu_start  = 1'b0;
      case (state)
         IDLE:    if (reset) req_ready = pick_onehot;
         ISSUE:   fpu_start = 1'b1;
         RESPOND: resp_valid = REQUESTERS'(1) << grant;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant   <= IW'(REQUESTERS - 1);
         grant        <= '0;
         counter      <= '0;
         fpu_first    <= '0;
         fpu_second   <= '0;
         fpu_z        <= '0;
         fpu_command  <= '0;
         resp_result  <= '0;
         resp_timeout <= 1'b0;
      end else begin
         if (accept) begin
            grant       <= pick_index;
            fpu_first   <= req_first[op_base +: bitness];
            fpu_second  <= req_second[op_base +: bitness];
            fpu_z       <= req_z[op_base +: bitness];
            fpu_command <= req_command[cmd_base +: command_size];
         end
         if (state == ISSUE) counter <= '0;
         if (state == WAIT) begin
            counter <= counter + 1'b1;
            if (done_ok) begin
               resp_result  <= fpu_result;
               resp_timeout <= 1'b0;
            end else if (timed_out) begin
               resp_result  <= '0;
               resp_timeout <= 1'b1;
            end
         end
         if (resp_hs) last_grant <= grant;
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small behavioural fpu model.
module tb_fpu_arbiter;
   import fpu_pkg::*;

   localparam int BW = 32;
   localparam int CS = 2;
   localparam int NR = 4;
   localparam int TO = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_ready;
   logic [NR*BW-1:0] req_first = '0;
   logic [NR*BW-1:0] req_second = '0;
   logic [NR*BW-1:0] req_z = '0;
   logic [NR*CS-1:0] req_command = '0;
   logic [NR-1:0]    resp_valid;
   logic [NR-1:0]    resp_ready = '0;
   logic [BW-1:0]    resp_result;
   logic             resp_timeout;
   logic             fpu_start;
   logic [BW-1:0]    fpu_first, fpu_second, fpu_z;
   logic [CS-1:0]    fpu_command;
   logic [BW-1:0]    fpu_result;
   logic             fpu_done;

   int checks = 0;
   int failures = 0;

   // fpu model: mode 0 = done 3 cycles after start, 1 = done stuck high, 2 = never done
   int fpu_mode = 0;
   int dly = 0;

   fpu_arbiter #(
      .bitness     (BW),
      .command_size(CS),
      .REQUESTERS  (NR),
      .TIMEOUT     (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_first   (req_first),
      .req_second  (req_second),
      .req_z       (req_z),
      .req_command (req_command),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_timeout(resp_timeout),
      .fpu_start   (fpu_start),
      .fpu_first   (fpu_first),
      .fpu_second  (fpu_second),
      .fpu_z       (fpu_z),
      .fpu_command (fpu_command),
      .fpu_result  (fpu_result),
      .fpu_done    (fpu_done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (fpu_start) dly = 1;
      else if (dly != 0 && dly < 100) dly = dly + 1;
   end

   always_comb begin
      fpu_done   = (fpu_mode == 1) || (fpu_mode == 0 && dly >= 4);
      fpu_result = (fpu_mode == 1) ? 32'hA000_0000 + 32'(dly) : 32'h4000_0000;
   end

   // Requests client c, waits for accept, then counts cycles until resp_valid (lat=-1 on timeout).
   task automatic run_op(input int c, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [BW-1:0] z, input logic [CS-1:0] cmd,
                         output int lat, output int starts);
      int n;
      req_first[c*BW +: BW]   = a;
      req_second[c*BW +: BW]  = b;
      req_z[c*BW +: BW]       = z;
      req_command[c*CS +: CS] = cmd;
      req_valid[c]            = 1'b1;
      lat    = -1;
      starts = 0;
      n      = 0;
      #1;
      while (!req_ready[c] && n < 20) begin
         @(negedge clock); #1;
         n++;
      end
      if (!req_ready[c]) return;
      @(negedge clock);
      req_valid[c] = 1'b0;
      #1;
      lat = 1;
      while (lat <= 30) begin
         if (fpu_start) starts++;
         if (resp_valid != '0) return;
         @(negedge clock); #1;
         lat++;
      end
      lat = -1;
   endtask

   task automatic release_resp(input int c);
      resp_ready[c] = 1'b1;
      @(negedge clock); #1;
      resp_ready = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if ({req_ready, resp_valid, fpu_start, resp_timeout} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: got rdy=%b rv=%b st=%b to=%b, need all 0",
                  req_ready, resp_valid, fpu_start, resp_timeout);
      end
      checks++;
      if ({fpu_first, fpu_second, fpu_z, fpu_command, resp_result} !== '0) begin
         failures++;
         $display("FAIL reset_regs: got first=%h result=%h cmd=%h, need 0",
                  fpu_first, resp_result, fpu_command);
      end
      reset = 1'b1;
      @(negedge clock); #1;
      checks++;
      if ({req_ready, resp_valid, fpu_start} !== '0) begin
         failures++;
         $display("FAIL after_reset: got rdy=%b rv=%b st=%b, need 0", req_ready, resp_valid, fpu_start);
      end
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [NR-1:0] rec [5];
      int at [5];
      int got = 0;
      fpu_mode   = 0;
      req_valid  = '1;
      resp_ready = '1;
      #1;
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         if (req_ready != '0) begin
            rec[got] = req_ready;
            at[got]  = cyc;
            got++;
         end
         @(negedge clock); #1;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= got || rec[i] !== exp_rr[i]) begin
            failures++;
            $display("FAIL rr_order[%0d]: got %b (accepts seen %0d), need %b",
                     i, (i < got) ? rec[i] : 4'bxxxx, got, exp_rr[i]);
         end
      end
      checks++;
      if (got < 2 || at[1] - at[0] !== 6) begin
         failures++;
         $display("FAIL rr_spacing: got %0d cycles, need 6", (got < 2) ? -1 : at[1] - at[0]);
      end
      req_valid = '0;
      repeat (8) @(negedge clock);
      #1;
      resp_ready = '0;
   endtask

   task automatic test_single();
      int lat, starts;
      fpu_mode = 0;
      run_op(2, 32'h3F80_0000, 32'h3F80_0000, 32'h0, CMD_ADD, lat, starts);
      checks++;
      if (lat !== 5) begin
         failures++;
         $display("FAIL single_latency: got %0d, need 5", lat);
      end
      checks++;
      if (starts !== 1) begin
         failures++;
         $display("FAIL single_start_pulse: got %0d cycles, need 1", starts);
      end
      checks++;
      if (resp_valid !== 4'b0100 || resp_result !== 32'h4000_0000 || resp_timeout !== 1'b0) begin
         failures++;
         $display("FAIL single_resp: got rv=%b res=%h to=%b, need 0100 40000000 0",
                  resp_valid, resp_result, resp_timeout);
      end
      checks++;
      if (fpu_first !== 32'h3F80_0000 || fpu_command !== CMD_ADD) begin
         failures++;
         $display("FAIL single_operands: got first=%h cmd=%h, need 3f800000 0", fpu_first, fpu_command);
      end
      release_resp(2);
      checks++;
      if (resp_valid !== '0) begin
         failures++;
         $display("FAIL single_release: got rv=%b, need 0000", resp_valid);
      end
   endtask

   task automatic test_stale_done();
      int lat, starts;
      fpu_mode = 1;
      run_op(1, 32'h4040_0000, 32'h3F80_0000, 32'h0, CMD_SUB, lat, starts);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL stale_latency: got %0d, need 4", lat);
      end
      checks++;
      if (resp_result !== 32'hA000_0003 || resp_valid !== 4'b0010) begin
         failures++;
         $display("FAIL stale_result: got res=%h rv=%b, need a0000003 0010", resp_result, resp_valid);
      end
      release_resp(1);
   endtask

   task automatic test_timeout();
      int lat, starts;
      fpu_mode = 2;
      run_op(3, 32'h4000_0000, 32'h4000_0000, 32'h0, CMD_DIV, lat, starts);
      checks++;
      if (lat !== 10) begin
         failures++;
         $display("FAIL timeout_latency: got %0d, need 10", lat);
      end
      checks++;
      if (resp_timeout !== 1'b1 || resp_result !== '0 || resp_valid !== 4'b1000) begin
         failures++;
         $display("FAIL timeout_resp: got to=%b res=%h rv=%b, need 1 00000000 1000",
                  resp_timeout, resp_result, resp_valid);
      end
      release_resp(3);
      fpu_mode = 0;
      run_op(0, 32'h4040_0000, 32'h0, 32'h0, CMD_ADD, lat, starts);
      checks++;
      if (lat !== 5 || resp_timeout !== 1'b0 || resp_result !== 32'h4000_0000) begin
         failures++;
         $display("FAIL timeout_recover: got lat=%0d to=%b res=%h, need 5 0 40000000",
                  lat, resp_timeout, resp_result);
      end
      release_resp(0);
   endtask

   task automatic test_backpressure();
      int lat, starts;
      fpu_mode = 0;
      run_op(0, 32'h0000_00A0, 32'h0000_00B0, 32'h0000_00C0, CMD_SUB, lat, starts);
      checks++;
      if (lat !== 5) begin
         failures++;
         $display("FAIL bp_latency: got %0d, need 5", lat);
      end
      req_first[1*BW +: BW]   = 32'h0000_0A11;
      req_command[1*CS +: CS] = CMD_MUL;
      req_valid[1]            = 1'b1;
      resp_ready              = 4'b1110;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (resp_valid !== 4'b0001 || resp_result !== 32'h4000_0000 || req_ready !== '0 ||
             fpu_first !== 32'h0000_00A0) begin
            failures++;
            $display("FAIL bp_hold[%0d]: got rv=%b res=%h rdy=%b first=%h, need 0001 40000000 0000 000000a0",
                     i, resp_valid, resp_result, req_ready, fpu_first);
         end
         @(negedge clock);
      end
      #1;
      resp_ready = 4'b0001;
      @(negedge clock); #1;
      resp_ready = '0;
      checks++;
      if (req_ready !== 4'b0010 || resp_valid !== '0) begin
         failures++;
         $display("FAIL bp_next_accept: got rdy=%b rv=%b, need 0010 0000", req_ready, resp_valid);
      end
      run_op(1, 32'h0000_0A11, 32'h0, 32'h0, CMD_MUL, lat, starts);
      checks++;
      if (lat !== 5 || fpu_first !== 32'h0000_0A11 || fpu_command !== CMD_MUL) begin
         failures++;
         $display("FAIL bp_second_op: got lat=%0d first=%h cmd=%h, need 5 00000a11 2",
                  lat, fpu_first, fpu_command);
      end
      release_resp(1);
   endtask

   task automatic test_reset_in_wait();
      int n = 0;
      fpu_mode = 2;
      req_first[2*BW +: BW] = 32'h1234_5678;
      req_valid[2] = 1'b1;
      #1;
      while (!req_ready[2] && n < 20) begin
         @(negedge clock); #1;
         n++;
      end
      @(negedge clock);
      req_valid = '0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (fpu_first !== 32'h1234_5678 || resp_valid !== '0) begin
         failures++;
         $display("FAIL rst_wait_setup: got first=%h rv=%b, need 12345678 0000", fpu_first, resp_valid);
      end
      reset = 1'b0;
      req_first[0 +: BW] = 32'h1111_1111;
      req_valid = '1;
      #1;
      checks++;
      if ({req_ready, resp_valid, fpu_start, resp_timeout} !== '0 ||
          {fpu_first, fpu_command, resp_result} !== '0) begin
         failures++;
         $display("FAIL rst_wait_outputs: got rdy=%b rv=%b st=%b first=%h res=%h, need all 0",
                  req_ready, resp_valid, fpu_start, fpu_first, resp_result);
      end
      @(negedge clock); #1;
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL rst_wait_regrant: got rdy=%b, need 0001", req_ready);
      end
      @(negedge clock); #1;
      req_valid = '0;
      checks++;
      if (fpu_start !== 1'b1 || fpu_first !== 32'h1111_1111) begin
         failures++;
         $display("FAIL rst_wait_reissue: got st=%b first=%h, need 1 11111111", fpu_start, fpu_first);
      end
      fpu_mode   = 0;
      resp_ready = '1;
      repeat (8) @(negedge clock);
      resp_ready = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_stale_done();
      test_timeout();
      test_backpressure();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one fpu instance among REQUESTERS clients and sequences each operation: round-robin grant, operand capture, FPU start pulse, completion wait with timeout, result return.
- Sits between the client units and the fpu; the fpu is not modified.
- The fpu has no start input, so the integrator maps fpu_start onto the fpu's restart input.

Parameters:
- bitness, 32, operand/result width; passed through to fpu.
- command_size, 2, fpu command width.
- REQUESTERS, 4, number of clients, 2..8.
- TIMEOUT, 64, max WAIT cycles before an op is abandoned; counter width $clog2(TIMEOUT+1).

Ports:
- clock  in  1  clock; all state on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  REQUESTERS  per-client request.
- req_ready  out  REQUESTERS  one-hot accept.
- req_first  in  REQUESTERS*bitness  client i at slice [i*bitness +: bitness].
- req_second  in  REQUESTERS*bitness  same packing as req_first.
- req_z  in  REQUESTERS*bitness  same packing as req_first.
- req_command  in  REQUESTERS*command_size  same packing.
- resp_valid  out  REQUESTERS  one-hot response to the granted client.
- resp_ready  in  REQUESTERS  client accepts response.
- resp_result  out  bitness  shared result bus; valid with resp_valid.
- resp_timeout  out  1  response is a timeout; resp_result is 0.
- fpu_start  out  1  one-cycle pulse that restarts the fpu.
- fpu_first, fpu_second, fpu_z  out  bitness each  registered operands.
- fpu_command  out  command_size  registered command.
- fpu_result  in  bitness  fpu result.
- fpu_done  in  1  fpu work_is_done.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESPOND. 2-bit shared enum.
- Reset (reset=0, async):
  - state=IDLE, last_grant=REQUESTERS-1, grant=0, counter=0.
  - All operand/result registers 0; resp_timeout=0.
  - req_ready, resp_valid and fpu_start are 0 during reset and immediately after.
- Reset mid-operation aborts the op with no response. The client must re-request.
- IDLE:
  - grant = first i with req_valid[i], searching last_grant+1 upward with wrap.
  - req_ready = onehot(grant) combinationally, only while in IDLE and some req_valid is 1; otherwise 0.
  - On handshake: latch the client's operands/command into fpu_* registers, register grant, go ISSUE.
- ISSUE: fpu_start=1 for exactly one cycle; counter cleared; go WAIT.
- WAIT:
  - Counter increments each cycle.
  - fpu_done is ignored in the first WAIT cycle, because the done flag is stale from the previous op.
  - From the second WAIT cycle on, fpu_done=1 captures fpu_result, sets resp_timeout=0, goes RESPOND.
  - If counter reaches TIMEOUT with no done: resp_result=0, resp_timeout=1, go RESPOND.
  - fpu_done and timeout in the same cycle: done wins.
- RESPOND:
  - resp_valid[grant]=1; resp_result and resp_timeout held stable.
  - On resp_ready[grant]=1: last_grant=grant, go IDLE.
  - resp_ready from other clients is ignored.
- fpu_* operand outputs stay stable from ISSUE until the next accept.
- Fixed latency, accept edge to resp_valid: 2 + number of WAIT cycles until done. Minimum is 4 cycles (ISSUE, WAIT×2).
- Throughput: one op in flight; at most one accept per RESPOND→IDLE.
- A client dropping req_valid before req_ready is legal; no state change results.

Decomposition:
- Package fpu_pkg:
  - state enum arb_state_t.
  - Width helper functions, replacing the EXP/MANT width macros for shared use.
  - Shared command encodings: CMD_ADD=0, CMD_SUB=1, CMD_MUL=2, CMD_DIV=3.
- Sub-module rr_pick (combinational): inputs req vector and last_grant; outputs onehot and index.
- The FSM, operand registers and timeout counter stay in fpu_arbiter.

Test Plan:
- Single client, REQUESTERS=4:
  - Stimulus: client 2 sends first=0x3F800000, cmd=0; bench fpu model asserts done 3 cycles after start with result 0x40000000.
  - Required: resp_valid=4'b0100, resp_result=0x40000000, resp_timeout=0, exactly 5 cycles after accept; fpu_start high for exactly 1 cycle.
- Round-robin:
  - Stimulus: all four req_valid held high, resp_ready tied 1.
  - Required: grant order 0,1,2,3,0; no client served twice while another waits.
- Stale done:
  - Stimulus: fpu_done held 1 continuously.
  - Required: response no earlier than the second WAIT cycle (latency 4); result captured from that cycle.
- Timeout:
  - Stimulus: TIMEOUT=8, fpu_done never asserted.
  - Required: resp_timeout=1, resp_result=0 after 8 WAIT cycles; next request is serviced normally.
- Response backpressure:
  - Stimulus: hold resp_ready=0 for 10 cycles while another client requests.
  - Required: resp_valid and resp_result stable; req_ready stays 0 throughout; new accept happens 1 cycle after the resp_ready handshake.
- Async reset in WAIT:
  - Stimulus: pulse reset low mid-WAIT.
  - Required: all outputs 0 immediately; state IDLE; grant restarts at client 0.
